stopwatch_bcd: RTL
==================

Name: stopwatch_bcd

Overview:
- Four-digit BCD stopwatch counter, directly downstream of the 1-in-10 tick divider.
- Consumes the divider's single-cycle tick as a count enable, applies start/stop and lap/clear control from two button inputs, and presents a registered 16-bit BCD value for the display-scan stage.
- All logic runs on the master clock; tick is never used as a clock.

Parameters:
- TICK_DIV, 1, number of tick pulses per BCD increment (1..16); prescaler width 4 bits.

Ports:
- mclk  input  1  master clock; all state changes on rising edge.
- rst  input  1  reset, asynchronous assert, active-low (0 = reset).
- tick  input  1  count enable from divider; high for exactly one mclk cycle per period.
- start_stop  input  1  button level, already synchronized/debounced; acted on at its rising edge.
- lap_clr  input  1  button level, already synchronized/debounced; acted on at its rising edge.
- disp  output  16  displayed value {d3,d2,d1,d0}, each digit BCD 0-9, d0 least significant.
- running  output  1  high in RUN or LAP.
- lap_active  output  1  high in LAP (display frozen).
- ovf  output  1  one-cycle pulse on wrap 9999 -> 0000.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (rst=0): state IDLE, count=0000, disp=0x0000, prescaler=0, running=0, lap_active=0, ovf=0, edge-detect registers=0. Reset takes effect mid-count with no completion of the pending increment.
- Edge detect: registered copies of start_stop/lap_clr; ss_evt = start_stop & ~prev, lc_evt likewise. Level held high yields exactly one event. A press occurring during reset is not seen unless the level rises again after reset.
- Priority: ss_evt and lc_evt in the same cycle -> ss_evt acted on, lc_evt discarded.
- FSM, applied at the mclk edge where the event is sampled:
  IDLE: ss -> RUN. lc -> IDLE (count/prescaler cleared, already zero).
  RUN: ss -> STOP. lc -> LAP (disp frozen at current count).
  LAP: ss -> STOP (disp returns to live count). lc -> RUN (disp returns to live count).
  STOP: ss -> RUN (resume, prescaler retained). lc -> IDLE (count and prescaler cleared to 0).
- Counting: only when state is RUN or LAP and tick=1.
  - The state before the transition decides, so a tick coinciding with the ss_evt that leaves RUN still counts.
  - A tick coinciding with the ss_evt leaving IDLE/STOP does not count.
- Prescaler: increments on qualifying tick. When it equals TICK_DIV-1 it returns to 0 and the BCD count increments.
- BCD increment: ripple per digit. A digit at 9 with carry-in goes to 0 and carries out. Digits never hold A-F.
  - 9999 + 1 -> 0000, with ovf=1 for exactly that one cycle. Counting continues after wrap.
- Latency: disp (live mode) and ovf update on the mclk edge that samples the qualifying tick; visible one cycle after tick is driven.
- disp: registered. Equals the count in IDLE/RUN/STOP; holds the snapshot in LAP. The count keeps advancing underneath.
- running/lap_active: registered, decoded from the next state, so they change in the same cycle as the state.
- lc in STOP clears the count in one cycle; disp=0x0000 on the next cycle.

Test Plan:
- Reset 3 cycles, release, TICK_DIV=1; ss press; 25 ticks spaced 10 cycles -> disp=0x0025, running=1, ovf never asserted.
- From 0x0025: lc press -> lap_active=1, disp stays 0x0025. 12 more ticks -> disp still 0x0025. lc press -> disp=0x0037 next cycle, lap_active=0.
- Preload to 0x9998 in RUN (run ticks) -> 2 ticks -> disp 0x9999 then 0x0000, ovf high exactly 1 cycle on the wrap edge.
- ss press in RUN -> STOP, 5 ticks -> disp unchanged. ss -> RUN, ticks resume counting. ss then lc -> disp=0x0000, state IDLE, running=0.
- TICK_DIV=10: RUN, 35 ticks -> disp=0x0003 (prescaler=5). STOP/RUN keeps prescaler: 5 more ticks -> 0x0004. ss and lc rising in same cycle from RUN -> STOP only, lap_active=0.
- rst low mid-RUN at 0x0417, asynchronous to mclk -> all outputs zero immediately. Release with start_stop held high -> no event until it falls and rises again.

Source files
------------

// File: rtl/stopwatch_bcd.sv
// Four-digit BCD stopwatch.
// The divider tick acts as a count enable, and two debounced buttons drive
// the run/stop and lap/clear control. The displayed value is registered and
// is frozen while a lap is shown. Everything runs on mclk.
module stopwatch_bcd #(
    parameter int TICK_DIV = 1
) (
    input  logic        mclk,
    input  logic        rst,
    input  logic        tick,
    input  logic        start_stop,
    input  logic        lap_clr,
    output logic [15:0] disp,
    output logic        running,
    output logic        lap_active,
    output logic        ovf
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2,
        LAP  = 2'd3
    } state_t;

    localparam logic [3:0] PRE_LAST = 4'(TICK_DIV - 1);

    state_t      state_reg, state_next;
    logic        ss_prev_reg, lc_prev_reg, armed_reg;
    logic        ss_evt, lc_evt;
    logic [3:0]  pre_reg, pre_next;
    logic [15:0] count_reg, count_next, count_inc;
    logic [15:0] disp_next;
    logic        running_next, lap_next;
    logic        count_en, step, clear, wrap;

    // Events are gated by armed_reg. The prev registers cannot follow the
    // buttons while reset is held, so the first cycle after release only
    // loads them. A button held through reset must fall and rise again
    // before it is seen as a press.
    assign ss_evt = armed_reg & start_stop & ~ss_prev_reg;
    assign lc_evt = armed_reg & lap_clr & ~lc_prev_reg & ~ss_evt;

    // Edge-detect registers: keep the previous button levels.
    always_ff @(posedge mclk or negedge rst) begin
        if (!rst) begin
            ss_prev_reg <= 1'b0;
            lc_prev_reg <= 1'b0;
            armed_reg   <= 1'b0;
        end else begin
            ss_prev_reg <= start_stop;
            lc_prev_reg <= lap_clr;
            armed_reg   <= 1'b1;
        end
    end

    // State register.
    always_ff @(posedge mclk or negedge rst) begin
        if (!rst) state_reg <= IDLE;
        else      state_reg <= state_next;
    end

    // Next-state logic. A start/stop event takes priority over lap/clear.
    always_comb begin
        state_next = state_reg;
        if (ss_evt) begin
            case (state_reg)
                IDLE:    state_next = RUN;
                RUN:     state_next = STOP;
                LAP:     state_next = STOP;
                STOP:    state_next = RUN;
                default: state_next = IDLE;
            endcase
        end else if (lc_evt) begin
            case (state_reg)
                IDLE:    state_next = IDLE;
                RUN:     state_next = LAP;
                LAP:     state_next = RUN;
                STOP:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Output decode from the next state, so the outputs move with the state.
    // While LAP persists the display holds its snapshot. Otherwise it follows
    // the count, including the increment made on this same edge.
    always_comb begin
        running_next = (state_next == RUN) || (state_next == LAP);
        lap_next     = (state_next == LAP);
        if ((state_reg == LAP) && (state_next == LAP)) disp_next = disp;
        else                                           disp_next = count_next;
    end

    // Counting is qualified by the state before the transition. A tick that
    // coincides with leaving RUN therefore still counts.
    assign count_en = tick & ((state_reg == RUN) || (state_reg == LAP));
    assign clear    = lc_evt & ((state_reg == IDLE) || (state_reg == STOP));
    assign step     = count_en & (pre_reg == PRE_LAST);

    // Prescaler: wraps to zero on the tick that advances the BCD count.
    always_comb begin
        pre_next = pre_reg;
        if (clear)             pre_next = 4'd0;
        else if (step)         pre_next = 4'd0;
        else if (count_en)     pre_next = pre_reg + 4'd1;
    end

    // Ripple BCD increment. A carry out of the top digit marks the wrap.
    always_comb begin
        logic carry;
        carry     = step;
        count_inc = count_reg;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (count_reg[4*i +: 4] == 4'd9) begin
                    count_inc[4*i +: 4] = 4'd0;
                end else begin
                    count_inc[4*i +: 4] = count_reg[4*i +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
        wrap       = carry;
        count_next = clear ? 16'h0000 : count_inc;
    end

    // Datapath and registered outputs.
    always_ff @(posedge mclk or negedge rst) begin
        if (!rst) begin
            pre_reg    <= 4'd0;
            count_reg  <= 16'h0000;
            disp       <= 16'h0000;
            ovf        <= 1'b0;
            running    <= 1'b0;
            lap_active <= 1'b0;
        end else begin
            pre_reg    <= pre_next;
            count_reg  <= count_next;
            disp       <= disp_next;
            ovf        <= wrap;
            running    <= running_next;
            lap_active <= lap_next;
        end
    end

endmodule
